mem_access_unit: RTL and testbench

Memory-stage sequencer for the pipelined LC-3b datapath. It takes the memory-related control bits the decoder places in the control word (mem_read, mem_write, is_ldi, is_sti, is_ldb_stb, is_trap), plus the EX-stage address and store data. It drives the data-memory (cache) handshake, runs two-access indirect sequences for LDI/STI, and aligns byte accesses for LDB/STB. It returns the load result and a stall to the pipeline control.

---
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage sequencer: drives the data-memory handshake, runs the two-access
// LDI/STI indirection and aligns byte lanes for LDB/STB.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        is_ldi,
    input  logic        is_sti,
    input  logic        is_ldb_stb,
    input  logic        is_trap,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        hold,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] load_data,
    output logic        mem_stall
);
    // state  | meaning
    // FIRST  | idle, or issuing the only access / the pointer fetch of LDI/STI
    // SECOND | indirect final access at the latched pointer
    // DONE   | op complete while pipeline held; presents latched load result
    localparam logic [1:0] ST_FIRST  = 2'd0;
    localparam logic [1:0] ST_SECOND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] data_q, data_d;

    logic        op, indirect, final_write;
    logic        req_rd, req_wr, final_acc;
    logic [15:0] acc_addr, acc_wdata, ld_val;
    logic [1:0]  acc_be;
    logic [7:0]  ld_byte;
    logic        trap_unused;

    assign op          = valid & (mem_read | mem_write);
    assign indirect    = is_ldi | is_sti;
    assign final_write = mem_write | is_sti;
    // TRAP is an ordinary word read; the flag carries no extra behaviour here.
    assign trap_unused = is_trap;

    always_comb begin
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        final_acc = 1'b0;
        acc_addr  = {addr[15:1], 1'b0};
        acc_wdata = wdata;
        acc_be    = 2'b11;
        case (state_q)
            ST_FIRST: begin
                if (op) begin
                    if (indirect) begin
                        req_rd = 1'b1;
                    end else begin
                        final_acc = 1'b1;
                        req_wr    = final_write;
                        req_rd    = ~final_write;
                        if (is_ldb_stb & final_write) begin
                            acc_wdata = {wdata[7:0], wdata[7:0]};
                            acc_be    = addr[0] ? 2'b10 : 2'b01;
                        end
                    end
                end
            end
            ST_SECOND: begin
                final_acc = 1'b1;
                req_wr    = is_sti;
                req_rd    = ~is_sti;
                acc_addr  = {ptr_q[15:1], 1'b0};
            end
            default: ;
        endcase
    end

    assign ld_byte = addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    assign ld_val  = (state_q == ST_FIRST && is_ldb_stb && !final_write)
                     ? {{8{ld_byte[7]}}, ld_byte} : dmem_rdata;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        case (state_q)
            ST_FIRST: begin
                if (op && dmem_resp) begin
                    if (indirect) begin
                        ptr_d   = dmem_rdata;
                        state_d = ST_SECOND;
                    end else if (hold) begin
                        data_d  = ld_val;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SECOND: begin
                if (dmem_resp) begin
                    if (hold) begin
                        data_d  = ld_val;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FIRST;
                    end
                end
            end
            ST_DONE: begin
                if (!hold) state_d = ST_FIRST;
            end
            default: state_d = ST_FIRST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FIRST;
            ptr_q   <= 16'h0000;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
        end
    end

    // Reset gates the request side combinationally so an in-flight access drops at once.
    assign dmem_read        = ~reset & req_rd;
    assign dmem_write       = ~reset & req_wr;
    assign dmem_address     = acc_addr;
    assign dmem_wdata       = acc_wdata;
    assign dmem_byte_enable = reset ? 2'b11 : acc_be;
    assign mem_stall        = ~reset & (req_rd | req_wr) & ~(final_acc & dmem_resp);
    assign load_data        = reset ? 16'h0000 : ((state_q == ST_DONE) ? data_q : ld_val);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: spec vector table, random single accesses
// against a behavioural model, and hand-written indirect / hold / reset sequences.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid, mem_read, mem_write, is_ldi, is_sti, is_ldb_stb, is_trap;
    logic [15:0] addr, wdata;
    logic        hold, dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read, dmem_write, mem_stall;
    logic [15:0] dmem_address, dmem_wdata, load_data;
    logic [1:0]  dmem_byte_enable;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef enum int {K_LDR, K_LDB, K_STR, K_STB, K_TRAP, K_LDI, K_STI} kind_t;

    typedef struct {
        kind_t       k;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rd;
        int          lat;
        logic [15:0] exp_addr;
        logic [15:0] exp_wd;
        logic [15:0] exp_ld;
        logic [1:0]  exp_be;
    } vec_t;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
        .is_ldi(is_ldi), .is_sti(is_sti), .is_ldb_stb(is_ldb_stb), .is_trap(is_trap),
        .addr(addr), .wdata(wdata), .hold(hold), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .load_data(load_data), .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        valid = 0; mem_read = 0; mem_write = 0; is_ldi = 0; is_sti = 0;
        is_ldb_stb = 0; is_trap = 0; dmem_resp = 0;
    endtask

    task automatic set_op(input kind_t k);
        idle();
        valid      = 1;
        mem_read   = (k == K_LDR || k == K_LDB || k == K_TRAP || k == K_LDI || k == K_STI);
        mem_write  = (k == K_STR || k == K_STB);
        is_ldi     = (k == K_LDI);
        is_sti     = (k == K_STI);
        is_ldb_stb = (k == K_LDB || k == K_STB);
        is_trap    = (k == K_TRAP);
    endtask

    function automatic vec_t model(kind_t k, logic [15:0] a, logic [15:0] wd, logic [15:0] rd, int lat);
        vec_t   v;
        logic [7:0] b;
        v.k = k; v.addr = a; v.wd = wd; v.rd = rd; v.lat = lat;
        v.exp_addr = a - (a % 2);
        v.exp_wd   = wd;
        v.exp_ld   = rd;
        v.exp_be   = 2'b11;
        if (k == K_LDB) begin
            b = 8'((a % 2) ? (rd >> 8) : rd);
            v.exp_ld = 16'($signed(b));
        end
        if (k == K_STB) begin
            v.exp_wd = wd[7:0] * 16'h0101;
            v.exp_be = (a % 2) ? 2'b10 : 2'b01;
        end
        return v;
    endfunction

    // Entered at posedge+1; returns at posedge+1 after the completing edge, idle inputs.
    task automatic run_single(input vec_t v);
        logic wr;
        wr = (v.k == K_STR || v.k == K_STB);
        set_op(v.k);
        addr = v.addr; wdata = v.wd; dmem_rdata = 16'hxxxx;
        #1;
        for (int c = 0; c < v.lat; c++) begin
            chk("stall_wait", 16'(mem_stall), 16'd1);
            chk("req_wait", 16'(wr ? dmem_write : dmem_read), 16'd1);
            @(posedge clk); #1;
        end
        dmem_resp = 1; dmem_rdata = v.rd;
        #1;
        chk("read", 16'(dmem_read), 16'(!wr));
        chk("write", 16'(dmem_write), 16'(wr));
        chk("address", dmem_address, v.exp_addr);
        chk("byte_en", 16'(dmem_byte_enable), 16'(v.exp_be));
        chk("stall_resp", 16'(mem_stall), 16'd0);
        if (wr) chk("wdata", dmem_wdata, v.exp_wd);
        else    chk("load_data", load_data, v.exp_ld);
        @(posedge clk); #1;
        idle();
    endtask

    vec_t table_v[8];

    initial begin
        vec_t v;
        table_v[0] = '{K_LDR,  16'h1235, 16'h0000, 16'hBEEF, 3, 16'h1234, 16'h0000, 16'hBEEF, 2'b11};
        table_v[1] = '{K_LDB,  16'h2001, 16'h0000, 16'h80AA, 0, 16'h2000, 16'h0000, 16'hFF80, 2'b11};
        table_v[2] = '{K_LDB,  16'h2000, 16'h0000, 16'h80AA, 1, 16'h2000, 16'h0000, 16'hFFAA, 2'b11};
        table_v[3] = '{K_STB,  16'h3001, 16'h1234, 16'h0000, 0, 16'h3000, 16'h3434, 16'h0000, 2'b10};
        table_v[4] = '{K_STB,  16'h3000, 16'h1234, 16'h0000, 2, 16'h3000, 16'h3434, 16'h0000, 2'b01};
        table_v[5] = '{K_STR,  16'h1001, 16'hA5A5, 16'h0000, 1, 16'h1000, 16'hA5A5, 16'h0000, 2'b11};
        table_v[6] = '{K_TRAP, 16'h0025, 16'h0000, 16'h0400, 0, 16'h0024, 16'h0000, 16'h0400, 2'b11};
        table_v[7] = '{K_LDB,  16'h2001, 16'h0000, 16'h7F00, 0, 16'h2000, 16'h0000, 16'h007F, 2'b11};

        idle(); hold = 0; addr = 16'h1235; wdata = 0; dmem_rdata = 0;
        reset = 1;
        set_op(K_LDR);
        #1;
        chk("rst_read", 16'(dmem_read), 16'd0);
        chk("rst_write", 16'(dmem_write), 16'd0);
        chk("rst_stall", 16'(mem_stall), 16'd0);
        chk("rst_load", load_data, 16'h0000);
        chk("rst_be", 16'(dmem_byte_enable), 16'h0003);
        @(posedge clk); @(posedge clk); #1;
        idle(); reset = 0;
        #1;

        for (int i = 0; i < 8; i++) run_single(table_v[i]);

        for (int i = 0; i < 40; i++) begin
            v = model(kind_t'($urandom_range(0, 4)), 16'($urandom), 16'($urandom),
                      16'($urandom), int'($urandom_range(0, 3)));
            run_single(v);
        end

        // stray response with nothing requested
        dmem_resp = 1; dmem_rdata = 16'h1111;
        #1;
        chk("stray_stall", 16'(mem_stall), 16'd0);
        chk("stray_read", 16'(dmem_read), 16'd0);
        @(posedge clk); #1;
        dmem_resp = 0;

        // LDI
        set_op(K_LDI); addr = 16'h4000;
        #1;
        chk("ldi_rd1", 16'(dmem_read), 16'd1);
        chk("ldi_a1", dmem_address, 16'h4000);
        dmem_resp = 1; dmem_rdata = 16'h5000;
        #1;
        chk("ldi_stall1", 16'(mem_stall), 16'd1);
        chk("ldi_a1_resp", dmem_address, 16'h4000);
        @(posedge clk); #1;
        dmem_resp = 0; dmem_rdata = 16'h0000;
        #1;
        chk("ldi_rd2", 16'(dmem_read), 16'd1);
        chk("ldi_a2", dmem_address, 16'h5000);
        chk("ldi_stall2", 16'(mem_stall), 16'd1);
        dmem_resp = 1; dmem_rdata = 16'h7777;
        #1;
        chk("ldi_stall_end", 16'(mem_stall), 16'd0);
        chk("ldi_load", load_data, 16'h7777);
        @(posedge clk); #1;
        idle();

        // STI
        set_op(K_STI); addr = 16'h4000; wdata = 16'hC0DE;
        #1;
        chk("sti_rd1", 16'(dmem_read), 16'd1);
        chk("sti_a1", dmem_address, 16'h4000);
        dmem_resp = 1; dmem_rdata = 16'h5000;
        @(posedge clk); #1;
        dmem_resp = 0;
        #1;
        chk("sti_wr2", 16'(dmem_write), 16'd1);
        chk("sti_rd2", 16'(dmem_read), 16'd0);
        chk("sti_a2", dmem_address, 16'h5000);
        chk("sti_wd", dmem_wdata, 16'hC0DE);
        chk("sti_be", 16'(dmem_byte_enable), 16'h0003);
        dmem_resp = 1;
        #1;
        chk("sti_stall_end", 16'(mem_stall), 16'd0);
        @(posedge clk); #1;
        idle();

        // completion while held
        set_op(K_LDR); addr = 16'h0100; hold = 1;
        dmem_resp = 1; dmem_rdata = 16'h1357;
        #1;
        chk("hold_stall", 16'(mem_stall), 16'd0);
        chk("hold_load0", load_data, 16'h1357);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            dmem_resp = 0; dmem_rdata = 16'hDEAD;
            #1;
            chk("done_read", 16'(dmem_read), 16'd0);
            chk("done_stall", 16'(mem_stall), 16'd0);
            chk("done_load", load_data, 16'h1357);
        end
        hold = 0;
        #1;
        chk("done_exit_load", load_data, 16'h1357);
        @(posedge clk); #1;
        addr = 16'h0200;
        #1;
        chk("after_done_read", 16'(dmem_read), 16'd1);
        chk("after_done_addr", dmem_address, 16'h0200);
        dmem_resp = 1; dmem_rdata = 16'h2468;
        @(posedge clk); #1;
        idle();

        // reset in LDI SECOND
        set_op(K_LDI); addr = 16'h4000;
        dmem_resp = 1; dmem_rdata = 16'h5000;
        @(posedge clk); #1;
        dmem_resp = 0;
        #1;
        chk("rs_second_addr", dmem_address, 16'h5000);
        reset = 1;
        #1;
        chk("rs_read", 16'(dmem_read), 16'd0);
        chk("rs_stall", 16'(mem_stall), 16'd0);
        chk("rs_load", load_data, 16'h0000);
        chk("rs_be", 16'(dmem_byte_enable), 16'h0003);
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("rs_reissue_read", 16'(dmem_read), 16'd1);
        chk("rs_reissue_addr", dmem_address, 16'h4000);
        dmem_resp = 1; dmem_rdata = 16'h5000;
        @(posedge clk); #1;
        dmem_rdata = 16'h7777;
        #1;
        chk("rs_second2_addr", dmem_address, 16'h5000);
        chk("rs_load_final", load_data, 16'h7777);
        @(posedge clk); #1;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
